dcache_miss_ctrl: RTL and testbench

//  Miss/refill controller for the MEM/WB data cache. It detects load/store misses, stalls the pipeline,

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_beat_counter.sv | 45 ++++
 rtl/dcache_miss_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared types, defaults and helpers for the data-cache miss path
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WB      = 2'd1,
        ST_REFILL  = 2'd2,
        ST_INSTALL = 2'd3
    } miss_state_e;

    localparam int LINE_WORDS_DEF = 4;
    localparam int WORD_OFF_W     = $clog2(LINE_WORDS_DEF);

    // Clears the byte-within-line offset bits of a byte address (4-byte words).
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned line_words);
        logic [63:0] span;
        span = 64'(line_words) << 2;
        return addr & ~(span - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_beat_counter.sv
// ============================================================================
// dcache_beat_counter : word-beat counter for line write-back / refill bursts
// Revision            : 1.0
// ============================================================================
`default_nettype none

module dcache_beat_counter #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] beat_o,
    output logic             last_o
);

    logic [IDX_W-1:0] beat_q;
    logic [IDX_W-1:0] beat_d;

    // LINE_WORDS is a power of two, so the increment wraps to 0 after the last beat.
    always_comb begin
        beat_d = beat_q;
        if (clear_i) begin
            beat_d = '0;
        end else if (advance_i) begin
            beat_d = beat_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == IDX_W'(LINE_WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
// ============================================================================
// dcache_miss_ctrl : MEM/WB data-cache miss detection, victim write-back,
//                    line refill and tag install; stalls the pipeline meanwhile
// Revision         : 1.0
// ============================================================================
`default_nettype none

module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid_i,
    input  logic                          req_write_i,
    input  logic [ADDR_W-1:0]             req_addr_i,
    input  logic                          hit_i,
    input  logic                          victim_dirty_i,
    input  logic [ADDR_W-1:0]             victim_base_i,
    output logic                          stall_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    input  logic                          mem_ack_i,
    output logic [$clog2(LINE_WORDS)-1:0] line_word_idx_o,
    output logic                          line_fill_we_o,
    output logic                          line_invalidate_o,
    output logic                          tag_update_o,
    output logic                          tag_dirty_o,
    output logic [31:0]                   miss_count_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);

    miss_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] victim_q, victim_d;
    logic              write_q, write_d;
    logic              refill_first_q, refill_first_d;
    logic [31:0]       miss_count_q;
    logic [31:0]       miss_count_d;

    logic              miss;
    logic              accept;
    logic              beat_clear;
    logic              beat_advance;
    logic [IDX_W-1:0]  beat;
    logic              beat_last;

    dcache_beat_counter #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_beat_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (beat_clear),
        .advance_i (beat_advance),
        .beat_o    (beat),
        .last_o    (beat_last)
    );

    assign miss = req_valid_i & ~hit_i;

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        beat_clear        = 1'b0;
        beat_advance      = 1'b0;
        stall_o           = 1'b0;
        mem_req_o         = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        line_fill_we_o    = 1'b0;
        line_invalidate_o = 1'b0;
        tag_update_o      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    stall_o    = 1'b1;
                    accept     = 1'b1;
                    beat_clear = 1'b1;
                    state_d    = victim_dirty_i ? ST_WB : ST_REFILL;
                end
            end
            ST_WB: begin
                stall_o      = 1'b1;
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = victim_q + ADDR_W'({beat, 2'b00});
                beat_advance = mem_ack_i;
                if (mem_ack_i && beat_last) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall_o           = 1'b1;
                mem_req_o         = 1'b1;
                mem_addr_o        = base_q + ADDR_W'({beat, 2'b00});
                line_invalidate_o = refill_first_q;
                line_fill_we_o    = mem_ack_i;
                beat_advance      = mem_ack_i;
                if (mem_ack_i && beat_last) begin
                    state_d = ST_INSTALL;
                end
            end
            ST_INSTALL: begin
                stall_o      = 1'b1;
                tag_update_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        base_d   = base_q;
        victim_d = victim_q;
        write_d  = write_q;
        if (accept) begin
            base_d   = ADDR_W'(line_base(64'(req_addr_i), LINE_WORDS));
            victim_d = victim_base_i;
            write_d  = req_write_i;
        end
    end

    // Invalidate only on the cycle that enters REFILL, regardless of wait states.
    assign refill_first_d = (state_d == ST_REFILL) && (state_q != ST_REFILL);

    assign miss_count_d = (accept && (miss_count_q != 32'hFFFF_FFFF)) ? miss_count_q + 32'd1
                                                                      : miss_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            victim_q       <= '0;
            write_q        <= 1'b0;
            refill_first_q <= 1'b0;
            miss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            victim_q       <= victim_d;
            write_q        <= write_d;
            refill_first_q <= refill_first_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign line_word_idx_o = beat;
    assign tag_dirty_o     = tag_update_o & write_q;
    assign miss_count_o    = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
// ============================================================================
// tb_dcache_miss_ctrl : directed self-checking bench for dcache_miss_ctrl
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_write, hit, victim_dirty, mem_ack;
    logic [31:0] req_addr, victim_base;
    logic        stall, mem_req, mem_we, line_fill_we, line_invalidate, tag_update, tag_dirty;
    logic [31:0] mem_addr, miss_count;
    logic [1:0]  line_word_idx;

    int checks = 0;
    int failures = 0;

    dcache_miss_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_write_i       (req_write),
        .req_addr_i        (req_addr),
        .hit_i             (hit),
        .victim_dirty_i    (victim_dirty),
        .victim_base_i     (victim_base),
        .stall_o           (stall),
        .mem_req_o         (mem_req),
        .mem_we_o          (mem_we),
        .mem_addr_o        (mem_addr),
        .mem_ack_i         (mem_ack),
        .line_word_idx_o   (line_word_idx),
        .line_fill_we_o    (line_fill_we),
        .line_invalidate_o (line_invalidate),
        .tag_update_o      (tag_update),
        .tag_dirty_o       (tag_dirty),
        .miss_count_o      (miss_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = 0; hit = 0;
        victim_dirty = 0; victim_base = 0; mem_ack = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stimulus only: one clean miss with ack tied high, 7 cycles, back to IDLE.
    task automatic run_clean_miss(input logic [31:0] addr);
        req_valid = 1; hit = 0; req_addr = addr; victim_dirty = 0; mem_ack = 1;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            req_valid = 0;
        end
        mem_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        next_cycle();
        #1;
        checks++;
        if ({stall, mem_req, line_fill_we, line_invalidate, tag_update} !== 5'b0 || miss_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: strobes=%b miss_count=%h required strobes=00000 miss_count=0",
                     {stall, mem_req, line_fill_we, line_invalidate, tag_update}, miss_count);
        end
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_hit();
        req_valid = 1; hit = 1; req_addr = 32'h0000_1234; mem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall !== 0 || mem_req !== 0 || line_fill_we !== 0) begin
                failures++;
                $display("FAIL hit_no_stall: stall=%b mem_req=%b fill_we=%b required 0 0 0", stall, mem_req, line_fill_we);
            end
            next_cycle();
        end
        idle_inputs();
        #1;
        checks++;
        if (miss_count !== 32'd0) begin
            failures++;
            $display("FAIL hit_count: miss_count=%0d required 0", miss_count);
        end
    endtask

    task automatic test_clean_miss();
        int stall_cycles = 0;
        int fills = 0;
        int tags = 0;
        req_valid = 1; hit = 0; req_addr = 32'h0000_1004; victim_dirty = 0; mem_ack = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (stall) stall_cycles++;
            if (line_fill_we) fills++;
            if (tag_update) tags++;
            checks++;
            if (i >= 1 && i <= 4) begin
                if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'(32'h1000 + 4 * (i - 1))
                    || line_word_idx !== 2'(i - 1)) begin
                    failures++;
                    $display("FAIL clean_refill_beat%0d: req=%b we=%b addr=%h idx=%0d required 1 0 %h %0d",
                             i - 1, mem_req, mem_we, mem_addr, line_word_idx, 32'(32'h1000 + 4 * (i - 1)), i - 1);
                end
            end else if (mem_req !== 0) begin
                failures++;
                $display("FAIL clean_no_req_cycle%0d: mem_req=%b required 0", i, mem_req);
            end
            checks++;
            if (line_invalidate !== (i == 1)) begin
                failures++;
                $display("FAIL clean_invalidate_cycle%0d: got %b required %b", i, line_invalidate, (i == 1));
            end
            next_cycle();
            req_valid = 0;
        end
        mem_ack = 0;
        checks++;
        if (stall_cycles != 6 || fills != 4 || tags != 1 || miss_count !== 32'd1) begin
            failures++;
            $display("FAIL clean_totals: stall=%0d fills=%0d tags=%0d count=%0d required 6 4 1 1",
                     stall_cycles, fills, tags, miss_count);
        end
    endtask

    task automatic test_dirty_miss();
        int stall_cycles = 0;
        logic [31:0] exp_addr;
        req_valid = 1; req_write = 1; hit = 0; req_addr = 32'h0000_3008;
        victim_dirty = 1; victim_base = 32'h0000_2000; mem_ack = 1;
        for (int i = 0; i < 11; i++) begin
            #1;
            if (stall) stall_cycles++;
            if (i >= 1 && i <= 4) begin
                exp_addr = 32'(32'h2000 + 4 * (i - 1));
                checks++;
                if (mem_req !== 1 || mem_we !== 1 || mem_addr !== exp_addr || line_fill_we !== 0) begin
                    failures++;
                    $display("FAIL dirty_wb_beat%0d: req=%b we=%b addr=%h fill=%b required 1 1 %h 0",
                             i - 1, mem_req, mem_we, mem_addr, line_fill_we, exp_addr);
                end
            end else if (i >= 5 && i <= 8) begin
                exp_addr = 32'(32'h3000 + 4 * (i - 5));
                checks++;
                if (mem_req !== 1 || mem_we !== 0 || mem_addr !== exp_addr || line_fill_we !== 1
                    || line_invalidate !== (i == 5)) begin
                    failures++;
                    $display("FAIL dirty_refill_beat%0d: req=%b we=%b addr=%h fill=%b inv=%b required 1 0 %h 1 %b",
                             i - 5, mem_req, mem_we, mem_addr, line_fill_we, line_invalidate, exp_addr, (i == 5));
                end
            end else if (i == 9) begin
                checks++;
                if (tag_update !== 1 || tag_dirty !== 1 || mem_req !== 0) begin
                    failures++;
                    $display("FAIL dirty_install: tag=%b dirty=%b req=%b required 1 1 0", tag_update, tag_dirty, mem_req);
                end
            end
            next_cycle();
            req_valid = 0; req_write = 0; victim_base = 32'h0000_9990; req_addr = 32'h0000_7777;
        end
        idle_inputs();
        checks++;
        if (stall_cycles != 10 || miss_count !== 32'd2) begin
            failures++;
            $display("FAIL dirty_totals: stall=%0d count=%0d required 10 2", stall_cycles, miss_count);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_addr;
        req_valid = 1; hit = 0; req_addr = 32'h0000_4010; victim_dirty = 0; mem_ack = 0;
        #1;
        checks++;
        if (stall !== 1 || mem_req !== 0) begin
            failures++;
            $display("FAIL wait_accept: stall=%b mem_req=%b required 1 0", stall, mem_req);
        end
        next_cycle();
        req_valid = 0;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 4; w++) begin
                mem_ack = (w == 3);
                exp_addr = 32'(32'h4010 + 4 * b);
                #1;
                checks++;
                if (mem_req !== 1 || mem_addr !== exp_addr || line_word_idx !== 2'(b)
                    || line_fill_we !== mem_ack || tag_update !== 0) begin
                    failures++;
                    $display("FAIL wait_beat%0d_cyc%0d: req=%b addr=%h idx=%0d fill=%b tag=%b required 1 %h %0d %b 0",
                             b, w, mem_req, mem_addr, line_word_idx, line_fill_we, tag_update, exp_addr, b, mem_ack);
                end
                next_cycle();
            end
        end
        mem_ack = 0;
        #1;
        checks++;
        if (tag_update !== 1 || tag_dirty !== 0) begin
            failures++;
            $display("FAIL wait_install: tag=%b dirty=%b required 1 0", tag_update, tag_dirty);
        end
        next_cycle();
        #1;
        checks++;
        if (stall !== 0 || miss_count !== 32'd3) begin
            failures++;
            $display("FAIL wait_done: stall=%b count=%0d required 0 3", stall, miss_count);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1; hit = 0; req_addr = 32'h0000_6000; victim_dirty = 0; mem_ack = 1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            req_valid = 0;
        end
        req_valid = 1; req_addr = 32'h0000_6024;
        #1;
        checks++;
        if (stall !== 1 || mem_req !== 0 || tag_update !== 0) begin
            failures++;
            $display("FAIL b2b_accept: stall=%b req=%b tag=%b required 1 0 0", stall, mem_req, tag_update);
        end
        next_cycle();
        req_valid = 0;
        #1;
        checks++;
        if (mem_req !== 1 || mem_addr !== 32'h0000_6020 || line_invalidate !== 1) begin
            failures++;
            $display("FAIL b2b_refill: req=%b addr=%h inv=%b required 1 00006020 1", mem_req, mem_addr, line_invalidate);
        end
        for (int i = 0; i < 5; i++) next_cycle();
        mem_ack = 0;
        #1;
        checks++;
        if (stall !== 0 || miss_count !== 32'd5) begin
            failures++;
            $display("FAIL b2b_done: stall=%b count=%0d required 0 5", stall, miss_count);
        end
    endtask

    task automatic test_reset_mid_refill();
        int tags = 0;
        req_valid = 1; hit = 0; req_addr = 32'h0000_5000; victim_dirty = 0; mem_ack = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            req_valid = 0;
        end
        #1;
        checks++;
        if (mem_req !== 1 || line_word_idx !== 2'd2 || mem_addr !== 32'h0000_5008) begin
            failures++;
            $display("FAIL rst_pre_beat2: req=%b idx=%0d addr=%h required 1 2 00005008", mem_req, line_word_idx, mem_addr);
        end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (mem_req !== 0 || stall !== 0 || miss_count !== 32'd0 || tag_update !== 0) begin
            failures++;
            $display("FAIL rst_async: req=%b stall=%b count=%0d tag=%b required 0 0 0 0",
                     mem_req, stall, miss_count, tag_update);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            if (tag_update) tags++;
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (tag_update) tags++;
            next_cycle();
        end
        mem_ack = 0;
        #1;
        checks++;
        if (tags != 0 || stall !== 0 || mem_req !== 0 || miss_count !== 32'd0) begin
            failures++;
            $display("FAIL rst_after: tags=%0d stall=%b req=%b count=%0d required 0 0 0 0",
                     tags, stall, mem_req, miss_count);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        force dut.miss_count_d = 32'hFFFF_FFFE;
        next_cycle();
        release dut.miss_count_d;
        #1;
        checks++;
        if (miss_count !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL sat_preload: count=%h required fffffffe", miss_count);
        end
        for (int m = 0; m < 3; m++) begin
            run_clean_miss(32'h0000_8000 + 32'(m * 16));
            #1;
            checks++;
            if (miss_count !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL sat_miss%0d: count=%h required ffffffff", m, miss_count);
            end
        end
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_refill();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
